// File: rtl/global_phase_normalize.sv
// Converts an integer global phase plus a pending count of 1/sqrt(2) factors into
// a fixed-point amplitude pair, applying factor pairs as halvings and an odd factor as a multiply.
module global_phase_normalize #(
    parameter int FRAC_BITS = 16,
    parameter int SQRT_HALF = 46341,
    parameter int MAX_H     = 80
) (
    input  logic               clk,
    input  logic               rst_new,
    input  logic               start_norm,
    input  logic signed [31:0] global_phase_r,
    input  logic signed [31:0] global_phase_i,
    input  logic        [31:0] count_H,
    output logic signed [31:0] amp_r,
    output logic signed [31:0] amp_i,
    output logic               busy,
    output logic               done_norm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCALE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic signed [31:0] POS_LIM = (32'sd1 <<< (31 - FRAC_BITS)) - 32'sd1;
    localparam logic signed [31:0] NEG_LIM = -(32'sd1 <<< (31 - FRAC_BITS));
    localparam logic signed [63:0] K64     = 64'(SQRT_HALF);
    localparam logic signed [63:0] RND64   = 64'sd1 <<< (FRAC_BITS - 1);
    localparam logic        [31:0] MAX_H_W = 32'(MAX_H);

    state_t             state_q;
    logic signed [31:0] work_r_q, work_i_q;
    logic        [31:0] rem_q;
    logic signed [31:0] amp_r_q, amp_i_q;
    logic               busy_q, done_q;

    logic signed [31:0] cap_r_d, cap_i_d, step_r_d, step_i_d;
    logic        [31:0] cap_rem_d, rem_step_d;

    function automatic logic signed [31:0] sat_shift(input logic signed [31:0] x);
        logic signed [31:0] y;
        if (x > POS_LIM) begin
            y = 32'sh7FFFFFFF;
        end else if (x < NEG_LIM) begin
            y = 32'sh80000000;
        end else begin
            y = x <<< FRAC_BITS;
        end
        return y;
    endfunction

    // Two 1/sqrt(2) factors combine into a rounded halving.
    function automatic logic signed [31:0] pair_step(input logic signed [31:0] x);
        logic signed [32:0] t;
        t = {x[31], x} + 33'sd1;
        return t[32:1];
    endfunction

    function automatic logic signed [31:0] single_step(input logic signed [31:0] x);
        logic signed [63:0] p;
        p = {{32{x[31]}}, x} * K64 + RND64;
        return p[FRAC_BITS +: 32];
    endfunction

    // Capture values and the next scaling step for the current working state.
    always_comb begin
        cap_r_d    = 32'sd0;
        cap_i_d    = 32'sd0;
        cap_rem_d  = 32'd0;
        step_r_d   = 32'sd0;
        step_i_d   = 32'sd0;
        rem_step_d = 32'd0;
        if (count_H > MAX_H_W) begin
            cap_r_d   = 32'sd0;
            cap_i_d   = 32'sd0;
            cap_rem_d = 32'd0;
        end else begin
            cap_r_d   = sat_shift(global_phase_r);
            cap_i_d   = sat_shift(global_phase_i);
            cap_rem_d = count_H;
        end
        if (rem_q >= 32'd2) begin
            step_r_d   = pair_step(work_r_q);
            step_i_d   = pair_step(work_i_q);
            rem_step_d = rem_q - 32'd2;
        end else begin
            step_r_d   = single_step(work_r_q);
            step_i_d   = single_step(work_i_q);
            rem_step_d = 32'd0;
        end
    end

    // Control FSM with registered outputs; steps keep running even once values hit zero.
    always_ff @(posedge clk) begin
        if (rst_new) begin
            state_q  <= IDLE;
            work_r_q <= 32'sd0;
            work_i_q <= 32'sd0;
            rem_q    <= 32'd0;
            amp_r_q  <= 32'sd0;
            amp_i_q  <= 32'sd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start_norm) begin
                        work_r_q <= cap_r_d;
                        work_i_q <= cap_i_d;
                        rem_q    <= cap_rem_d;
                        busy_q   <= 1'b1;
                        state_q  <= SCALE;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                SCALE: begin
                    if (rem_q == 32'd0) begin
                        amp_r_q <= work_r_q;
                        amp_i_q <= work_i_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        work_r_q <= step_r_d;
                        work_i_q <= step_i_d;
                        rem_q    <= rem_step_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign amp_r     = amp_r_q;
    assign amp_i     = amp_i_q;
    assign busy      = busy_q;
    assign done_norm = done_q;

endmodule

// File: tb/tb_global_phase_normalize.sv
// Directed bench for global_phase_normalize: hand-computed amplitudes, latencies and reset behaviour.
module tb_global_phase_normalize;

    logic               clk = 1'b0;
    logic               rst_new;
    logic               start_norm;
    logic signed [31:0] global_phase_r;
    logic signed [31:0] global_phase_i;
    logic        [31:0] count_H;
    logic signed [31:0] amp_r;
    logic signed [31:0] amp_i;
    logic               busy;
    logic               done_norm;

    int total = 0;
    int bad   = 0;

    global_phase_normalize dut (
        .clk            (clk),
        .rst_new        (rst_new),
        .start_norm     (start_norm),
        .global_phase_r (global_phase_r),
        .global_phase_i (global_phase_i),
        .count_H        (count_H),
        .amp_r          (amp_r),
        .amp_i          (amp_i),
        .busy           (busy),
        .done_norm      (done_norm)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] r, input logic [31:0] i,
                          input logic [31:0] h, input logic [31:0] er, input logic [31:0] ei,
                          input int elat);
        int          cyc;
        int          bcnt;
        logic        held;
        logic [31:0] hr, hi;
        global_phase_r = r;
        global_phase_i = i;
        count_H        = h;
        start_norm     = 1'b1;
        hr             = amp_r;
        hi             = amp_i;
        tick();
        start_norm     = 1'b0;
        global_phase_r = ~r;
        global_phase_i = ~i;
        count_H        = 32'd7;
        cyc  = 0;
        bcnt = 0;
        held = 1'b1;
        while (!done_norm && cyc < 100) begin
            if (busy) bcnt++;
            if (amp_r !== hr || amp_i !== hi) held = 1'b0;
            tick();
            cyc++;
        end
        chk({tag, ".latency"}, 32'(cyc), 32'(elat));
        chk({tag, ".busy_cycles"}, 32'(bcnt), 32'(elat));
        chk({tag, ".amp_held"}, {31'd0, held}, 32'd1);
        chk({tag, ".busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, ".amp_r"}, amp_r, er);
        chk({tag, ".amp_i"}, amp_i, ei);
        tick();
        chk({tag, ".done_one_cycle"}, {31'd0, done_norm}, 32'd0);
    endtask

    initial begin
        int dones;
        int first_cycle;
        rst_new        = 1'b1;
        start_norm     = 1'b0;
        global_phase_r = 32'sd0;
        global_phase_i = 32'sd0;
        count_H        = 32'd0;
        tick();
        tick();
        rst_new = 1'b0;
        chk("reset.amp_r", amp_r, 32'd0);
        chk("reset.amp_i", amp_i, 32'd0);
        chk("reset.busy", {31'd0, busy}, 32'd0);
        chk("reset.done", {31'd0, done_norm}, 32'd0);

        run_op("h0",     32'sd1, 32'sd0, 32'd0, 32'sd65536, 32'sd0, 1);
        run_op("h1",     32'sd1, 32'sd0, 32'd1, 32'sd46341, 32'sd0, 2);
        run_op("h3",     32'sd1, 32'sd0, 32'd3, 32'sd23171, 32'sd0, 3);
        run_op("h2neg",  32'sd0, -32'sd1, 32'd2, 32'sd0, -32'sd32768, 2);
        run_op("sat",    32'sd40000, -32'sd40000, 32'd0, 32'h7FFFFFFF, 32'h80000000, 1);
        run_op("h1mix",  -32'sd3, 32'sd5, 32'd1, -32'sd139023, 32'sd231705, 2);
        run_op("hmax",   32'sd1, -32'sd1, 32'd80, 32'sd1, 32'sd0, 41);
        run_op("hmax1",  32'sd1, -32'sd1, 32'd81, 32'sd0, 32'sd0, 1);
        run_op("h100",   32'sd1, 32'sd1, 32'd100, 32'sd0, 32'sd0, 1);

        // Reset in the middle of a scaling run discards it and clears the outputs.
        run_op("pre_rst", 32'sd1, 32'sd0, 32'd0, 32'sd65536, 32'sd0, 1);
        global_phase_r = 32'sd1;
        global_phase_i = 32'sd1;
        count_H        = 32'd4;
        start_norm     = 1'b1;
        tick();
        start_norm = 1'b0;
        tick();
        chk("mid.busy_before_rst", {31'd0, busy}, 32'd1);
        rst_new = 1'b1;
        tick();
        rst_new = 1'b0;
        chk("mid_rst.busy", {31'd0, busy}, 32'd0);
        chk("mid_rst.done", {31'd0, done_norm}, 32'd0);
        chk("mid_rst.amp_r", amp_r, 32'd0);
        chk("mid_rst.amp_i", amp_i, 32'd0);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done_norm) dones++;
        end
        chk("mid_rst.no_done", 32'(dones), 32'd0);

        rst_new    = 1'b1;
        start_norm = 1'b1;
        tick();
        rst_new    = 1'b0;
        start_norm = 1'b0;
        chk("rst_start.busy", {31'd0, busy}, 32'd0);
        tick();
        chk("rst_start.busy2", {31'd0, busy}, 32'd0);

        // start_norm held high: one accept per IDLE/DONE window, identical results.
        global_phase_r = 32'sd2;
        global_phase_i = -32'sd3;
        count_H        = 32'd4;
        start_norm     = 1'b1;
        dones          = 0;
        first_cycle    = 0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 10) start_norm = 1'b0;
            if (done_norm) begin
                dones++;
                if (dones == 1) first_cycle = k;
                chk("b2b.amp_r", amp_r, 32'sd32768);
                chk("b2b.amp_i", amp_i, -32'sd49152);
            end
            if (k == 5) chk("b2b.rearmed", {31'd0, busy}, 32'd1);
        end
        chk("b2b.count", 32'(dones), 32'd3);
        chk("b2b.first_done", 32'(first_cycle), 32'd4);
        chk("b2b.idle_busy", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/global_phase_normalize.md
GLOBAL_PHASE_NORMALIZE -- requirements
Module: global_phase_normalize

Interface
REQ-001 The module SHALL have parameter FRAC_BITS, default 16, the number of fractional bits of the amplitude outputs.
REQ-002 The module SHALL have parameter SQRT_HALF, default 46341, which is 0.707107 expressed in Q(32-FRAC_BITS).FRAC_BITS.
REQ-003 The module SHALL have parameter MAX_H, default 80, the count_H limit above which the result is forced to zero.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_new, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port start_norm, input, 1 bit: request to normalize the present global phase.
REQ-007 Port global_phase_r, input, 32 bits signed: integer real part of the global phase from the phase-maintenance stage.
REQ-008 Port global_phase_i, input, 32 bits signed: integer imaginary part of the same global phase.
REQ-009 Port count_H, input, 32 bits unsigned: number of pending 0.707107 factors, one per Hadamard.
REQ-010 Port amp_r, output, 32 bits signed: normalized real amplitude in fixed point with FRAC_BITS fractional bits.
REQ-011 Port amp_i, output, 32 bits signed: normalized imaginary amplitude in the same format.
REQ-012 Port busy, output, 1 bit: high while a normalization is in progress.
REQ-013 Port done_norm, output, 1 bit: one-cycle pulse marking amp_r/amp_i valid.

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, SCALE and DONE, and SHALL leave reset in IDLE.
REQ-015 In IDLE or DONE, start_norm=1 at edge E0 SHALL capture the inputs, set busy=1 and enter SCALE.
REQ-016 start_norm SHALL be ignored while busy=1, and captured inputs SHALL NOT change during the operation.
REQ-017 At capture, each phase component SHALL be shifted left by FRAC_BITS.
REQ-018 At capture, a component above 32767 SHALL saturate to 0x7FFFFFFF and a component below -32768 SHALL saturate to 0x80000000.
REQ-019 At capture, the working remainder SHALL be set to rem=count_H.
REQ-020 At capture, if count_H>MAX_H, both working values SHALL be forced to 0 and rem to 0.
REQ-021 Each edge in SCALE with rem>=2 SHALL perform a pair step: each component becomes (x+1)>>>1 (arithmetic shift, 33-bit intermediate) and rem decrements by 2.
REQ-022 Each edge in SCALE with rem==1 SHALL perform a single step: each component becomes (x*SQRT_HALF + 2^(FRAC_BITS-1))>>>FRAC_BITS (64-bit product, low 32 bits kept) and rem becomes 0.
REQ-023 The edge in SCALE where rem==0 SHALL load amp_r/amp_i from the working values, pulse done_norm=1, clear busy and enter DONE.
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE unless start_norm is accepted in that cycle.
REQ-025 Latency SHALL be: done_norm high in the cycle after edge E0+1+ceil(n/2), where n=count_H if count_H<=MAX_H and n=0 otherwise.
REQ-026 amp_r/amp_i SHALL hold their last result until the next done_norm and SHALL NOT change while busy.
REQ-027 If both working values reach 0 before rem==0, the FSM SHALL still run the remaining steps, so latency stays fixed by count_H.
REQ-028 count_H=0 SHALL produce the saturated and shifted phase unchanged.

Reset
REQ-029 rst_new=1 at any edge, including mid-SCALE, SHALL set state=IDLE, busy=0, done_norm=0, amp_r=0, amp_i=0, rem=0 and working values=0.
REQ-030 An operation interrupted by reset SHALL be discarded, with no done_norm pulse for it.
REQ-031 A start_norm coincident with rst_new SHALL be ignored.

Verification
REQ-032 Phase (1,0), count_H=0 -> done one cycle after E0+1; amp=(65536,0).
REQ-033 Phase (1,0), count_H=1 -> amp=(46341,0); count_H=3 -> amp=(23171,0) after 2 steps.
REQ-034 Phase (0,-1), count_H=2 -> amp=(0,-32768); busy high 2 cycles.
REQ-035 Phase (40000,-40000), count_H=0 -> amp=(0x7FFFFFFF,0x80000000).
REQ-036 Phase (1,1), count_H=100 -> amp=(0,0) with count_H=0 latency; then count_H=4 started, rst_new pulsed mid-SCALE -> no done_norm and all outputs 0.
REQ-037 start_norm held high for 10 cycles, count_H=4 -> exactly one accept per IDLE/DONE window; back-to-back results are identical.
